// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory port arbiter; the hazard unit imports
// these too so both sides agree on state and owner values.
package dmem_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between instruction fetch and the MEM
// stage: data has priority, a streak limiter keeps fetch moving.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic [AW-1:0] m_address,
    output logic          m_read_en,
    output logic          m_write_en,
    output logic [DW-1:0] m_write_data,
    input  logic [DW-1:0] m_read_data
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [CW-1:0] CNT_INIT   = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    logic [1:0]    state;
    logic          owner;
    logic [CW-1:0] cnt;
    logic [SW-1:0] streak;
    logic [AW-1:0] lat_addr;
    logic          lat_we;
    logic [DW-1:0] lat_wdata;
    logic          grant_d;
    logic          grant_if;

    function automatic logic [SW-1:0] streak_sat_inc(input logic [SW-1:0] s);
        return (s >= STREAK_MAX) ? STREAK_MAX : s + 1'b1;
    endfunction

    // Data wins unless fetch is waiting and data has used up its streak.
    assign grant_d  = d_req && (!if_req || (streak < STREAK_MAX));
    assign grant_if = !grant_d && if_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= OWN_IF;
            cnt      <= '0;
            streak   <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state  <= BUSY;
                        owner  <= OWN_D;
                        cnt    <= CNT_INIT;
                        streak <= if_req ? streak_sat_inc(streak) : '0;
                    end else if (grant_if) begin
                        state  <= BUSY;
                        owner  <= OWN_IF;
                        cnt    <= CNT_INIT;
                        streak <= '0;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        if (!lat_we) begin
                            if (owner == OWN_D) d_rdata  <= m_read_data;
                            else                if_rdata <= m_read_data;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Command registers only matter while BUSY, so they carry no reset.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && (grant_d || grant_if)) begin
            lat_addr  <= grant_d ? d_addr : if_addr;
            lat_we    <= grant_d && d_we;
            lat_wdata <= grant_d ? d_wdata : '0;
        end
    end

    always_comb begin
        m_address    = '0;
        m_read_en    = 1'b0;
        m_write_en   = 1'b0;
        m_write_data = '0;
        if (state == BUSY) begin
            m_address    = lat_addr;
            m_read_en    = !lat_we;
            m_write_en   = lat_we;
            m_write_data = lat_wdata;
        end
    end

    assign if_ready = (state == DONE) && (owner == OWN_IF);
    assign d_ready  = (state == DONE) && (owner == OWN_D);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) against
// a transaction-level schedule model plus directed literal expectations.
module tb_dmem_port_arbiter;

    localparam int MAXS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    logic        if_req[2], if_ready[2], d_req[2], d_we[2], d_ready[2];
    logic        m_read_en[2], m_write_en[2];
    logic [31:0] if_addr[2], if_rdata[2], d_addr[2], d_wdata[2], d_rdata[2];
    logic [31:0] m_address[2], m_write_data[2], m_read_data[2];

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_STREAK(MAXS)) u0 (
        .clk(clk), .reset(reset),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ready(if_ready[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_ready(d_ready[0]),
        .m_address(m_address[0]), .m_read_en(m_read_en[0]), .m_write_en(m_write_en[0]),
        .m_write_data(m_write_data[0]), .m_read_data(m_read_data[0])
    );

    dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_STREAK(MAXS)) u1 (
        .clk(clk), .reset(reset),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ready(if_ready[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_ready(d_ready[1]),
        .m_address(m_address[1]), .m_read_en(m_read_en[1]), .m_write_en(m_write_en[1]),
        .m_write_data(m_write_data[1]), .m_read_data(m_read_data[1])
    );

    function automatic logic [31:0] init_word(input int k);
        if (k == 32'h40) return 32'hDEADBEEF;
        return 32'hA000_0000 | 32'(k);
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Memories seen by the DUTs (combinational read, write on the clock edge)
    logic [31:0] bmem0[256], bmem1[256];
    bit loaded = 1'b0;
    assign m_read_data[0] = bmem0[m_address[0][7:0]];
    assign m_read_data[1] = bmem1[m_address[1][7:0]];

    always @(posedge clk) begin
        if (!loaded) begin
            for (int k = 0; k < 256; k++) begin
                bmem0[k] <= init_word(k);
                bmem1[k] <= init_word(k);
            end
            loaded <= 1'b1;
        end else begin
            if (m_write_en[0]) bmem0[m_address[0][7:0]] <= m_write_data[0];
            if (m_write_en[1]) bmem1[m_address[1][7:0]] <= m_write_data[1];
        end
    end

    // Schedule model: an access occupies the port for LAT command cycles, one
    // ready cycle and one idle cycle after the grant edge.
    logic [31:0] mmem[2][256];
    bit          mloaded = 1'b0;
    bit          active[2];
    int          since[2];
    int          streak[2];
    logic        owner_d[2], mwe[2];
    logic [31:0] maddr[2], mwdata[2], exp_ir[2], exp_dr[2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            if (!mloaded) begin
                for (int k = 0; k < 256; k++) begin
                    mmem[0][k] <= init_word(k);
                    mmem[1][k] <= init_word(k);
                end
                mloaded <= 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                active[i] <= 1'b0;
                since[i]  <= 0;
                streak[i] <= 0;
                exp_ir[i] <= '0;
                exp_dr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!active[i]) begin
                    if (d_req[i] && (!if_req[i] || streak[i] < MAXS)) begin
                        active[i]  <= 1'b1;
                        since[i]   <= 0;
                        owner_d[i] <= 1'b1;
                        maddr[i]   <= d_addr[i];
                        mwe[i]     <= d_we[i];
                        mwdata[i]  <= d_wdata[i];
                        streak[i]  <= if_req[i] ? ((streak[i] + 1 > MAXS) ? MAXS : streak[i] + 1) : 0;
                    end else if (if_req[i]) begin
                        active[i]  <= 1'b1;
                        since[i]   <= 0;
                        owner_d[i] <= 1'b0;
                        maddr[i]   <= if_addr[i];
                        mwe[i]     <= 1'b0;
                        mwdata[i]  <= '0;
                        streak[i]  <= 0;
                    end
                end else begin
                    since[i] <= since[i] + 1;
                    if (since[i] + 1 == lat_of(i)) begin
                        if (mwe[i])          mmem[i][maddr[i][7:0]] <= mwdata[i];
                        else if (owner_d[i]) exp_dr[i] <= mmem[i][maddr[i][7:0]];
                        else                 exp_ir[i] <= mmem[i][maddr[i][7:0]];
                    end
                    if (since[i] + 1 == lat_of(i) + 1) active[i] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [131:0] g, e;
        bit busy, done;
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                busy = active[i] && (since[i] < lat_of(i));
                done = active[i] && (since[i] == lat_of(i));
                e = {busy ? maddr[i] : 32'h0, busy && !mwe[i], busy && mwe[i],
                     busy ? mwdata[i] : 32'h0, done && !owner_d[i], done && owner_d[i],
                     exp_ir[i], exp_dr[i]};
                g = {m_address[i], m_read_en[i], m_write_en[i], m_write_data[i],
                     if_ready[i], d_ready[i], if_rdata[i], d_rdata[i]};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL cycle_compare inst=%0d t=%0t got=%h expected=%h", i, $time, g, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // One request held until its ready; reports data, latency and command cycles.
    task automatic access(input int i, input bit is_if, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat,
                          output int ren, output int wen, output logic [31:0] caddr);
        int n;
        bit got;
        @(posedge clk); #1;
        if (is_if) begin
            if_req[i] = 1'b1; if_addr[i] = a;
        end else begin
            d_req[i] = 1'b1; d_we[i] = we; d_addr[i] = a; d_wdata[i] = wd;
        end
        n = 0; got = 0; ren = 0; wen = 0; caddr = '0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (m_read_en[i])  ren++;
            if (m_write_en[i]) wen++;
            if (m_read_en[i] || m_write_en[i]) caddr = m_address[i];
            if (is_if ? if_ready[i] : d_ready[i]) got = 1;
        end
        rd = is_if ? if_rdata[i] : d_rdata[i];
        if (is_if) if_req[i] = 1'b0; else d_req[i] = 1'b0;
        check("access_timeout", 64'(got), 64'd1);
        lat = n - 1;
    endtask

    initial begin
        logic [31:0] rd, ca, ir;
        int lat, ren, wen, n, dcount, phase, t_if, t_d, r0, r1, nr;
        for (int i = 0; i < 2; i++) begin
            if_req[i] = 0; if_addr[i] = '0; d_req[i] = 0; d_we[i] = 0;
            d_addr[i] = '0; d_wdata[i] = '0;
        end
        #2 reset = 1'b0;
        #1 armed = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_m_read_en", 64'(m_read_en[0]), 64'd0);
        check("rst_m_write_en", 64'(m_write_en[0]), 64'd0);
        check("rst_d_ready", 64'(d_ready[0]), 64'd0);
        check("rst_rdata", {if_rdata[0], d_rdata[0]}, 64'd0);
        @(posedge clk); #1 reset = 1'b1;

        access(0, 0, 1'b1, 32'h12, 32'h55, rd, lat, ren, wen, ca);
        check("store_lat", 64'(lat), 64'd2);
        check("store_wen_cycles", 64'(wen), 64'd1);
        check("store_addr", 64'(ca), 64'h12);
        check("store_d_rdata", 64'(rd), 64'd0);

        access(0, 0, 1'b0, 32'h12, 32'h0, rd, lat, ren, wen, ca);
        check("load_lat", 64'(lat), 64'd2);
        check("load_ren_cycles", 64'(ren), 64'd1);
        check("load_data", 64'(rd), 64'h55);

        access(0, 1, 1'b0, 32'h40, 32'h0, rd, lat, ren, wen, ca);
        check("fetch_lat", 64'(lat), 64'd2);
        check("fetch_data", 64'(rd), 64'hDEADBEEF);
        check("fetch_wen_cycles", 64'(wen), 64'd0);

        // Both requesters held: four data grants, one fetch, then data again.
        @(posedge clk); #1;
        if_req[0] = 1'b1; if_addr[0] = 32'h44;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h12;
        dcount = 0; phase = 0; n = 0; t_if = 0; t_d = 0; ir = '0;
        while (phase < 2 && n < 80) begin
            @(negedge clk);
            n++;
            if (phase == 0) begin
                if (d_ready[0]) dcount++;
                if (if_ready[0]) begin
                    ir = if_rdata[0]; if_req[0] = 1'b0; phase = 1; t_if = n;
                end
            end else if (d_ready[0]) begin
                d_req[0] = 1'b0; phase = 2; t_d = n;
            end
        end
        check("arb_done", 64'(phase), 64'd2);
        check("arb_data_streak", 64'(dcount), 64'd4);
        check("arb_fetch_data", 64'(ir), 64'hA000_0044);
        check("arb_next_data_gap", 64'(t_d - t_if), 64'd3);

        // Reset during the command cycle of a store.
        @(posedge clk); #1;
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h20; d_wdata[0] = 32'h77;
        @(posedge clk); #1;
        check("abort_cmd_active", 64'(m_write_en[0]), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_wen_drop", 64'(m_write_en[0]), 64'd0);
        d_req[0] = 1'b0;
        nr = 0;
        repeat (3) begin
            @(negedge clk);
            if (d_ready[0]) nr++;
        end
        check("abort_no_ready", 64'(nr), 64'd0);
        check("abort_rdata_cleared", 64'(d_rdata[0]), 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        access(0, 0, 1'b0, 32'h12, 32'h0, rd, lat, ren, wen, ca);
        check("post_abort_load", 64'(rd), 64'h55);
        check("post_abort_lat", 64'(lat), 64'd2);

        // MEM_LAT=3 instance
        access(1, 0, 1'b1, 32'h30, 32'hA5, rd, lat, ren, wen, ca);
        check("lat3_store_lat", 64'(lat), 64'd4);
        check("lat3_store_wen", 64'(wen), 64'd3);
        access(1, 0, 1'b0, 32'h30, 32'h0, rd, lat, ren, wen, ca);
        check("lat3_load_lat", 64'(lat), 64'd4);
        check("lat3_load_ren", 64'(ren), 64'd3);
        check("lat3_load_data", 64'(rd), 64'hA5);

        @(posedge clk); #1;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h30;
        n = 0; r0 = -1; r1 = -1;
        while (r1 < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (d_ready[1]) begin
                if (r0 < 0) r0 = n; else r1 = n;
            end
        end
        d_req[1] = 1'b0;
        check("lat3_grant_spacing", 64'(r1 - r0), 64'd5);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters: instruction fetch (IF, read-only) and the MEM pipeline stage (read/write).
- Drives the memory's address, read enable, write enable and write data, and waits a fixed memory latency.
- Returns read data and a one-cycle ready pulse to the requester that owns the access.
- Data accesses have priority. A streak limiter guarantees fetch forward progress.
- Sits between the IF/MEM stages and the data memory. The hazard unit stalls a stage while its req is high and its ready is low.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles the memory command is held before read data is sampled; must be >= 1
- MAX_STREAK, 4, consecutive data grants allowed while fetch waits; must be >= 1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  AW  fetch address; stable while if_req is high
- if_rdata  out  DW  fetched word, valid when if_ready is high
- if_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load; stable while d_req is high
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data, valid when d_ready is high
- d_ready  out  1  one-cycle completion pulse for the data access
- m_address  out  AW  memory address
- m_read_en  out  1  memory read enable
- m_write_en  out  1  memory write enable
- m_write_data  out  DW  memory write data
- m_read_data  in  DW  memory read data

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, owner = none, cnt = 0, streak = 0.
  - All outputs 0, including if_rdata and d_rdata.
  - A reset during BUSY aborts the access: m_*_en drop immediately and no ready pulse is issued. A write may or may not have landed in memory.
- States:
  - IDLE: no command driven, m_* = 0.
    - If d_req and (!if_req or streak < MAX_STREAK): grant DATA, go to BUSY.
    - Else if if_req: grant IF, go to BUSY.
    - On grant, the requester's address, we and wdata are latched into internal registers and cnt = MEM_LAT-1.
  - BUSY: m_address, m_write_data, m_read_en (= !we) and m_write_en (= we) are driven from the latched registers. IF grants always read.
    - cnt decrements each cycle.
    - At cnt == 0 the clock edge samples m_read_data into the owner's rdata register, on reads only. A store leaves d_rdata unchanged.
    - Then go to DONE.
  - DONE: the owner's ready is high for exactly this cycle. m_* = 0. No grant is issued. Next state is IDLE.
- Timing:
  - Access time from req sampled in IDLE to the ready cycle is MEM_LAT+1 cycles.
  - Minimum spacing between grants is MEM_LAT+2 cycles.
  - With MEM_LAT=1: req in cycle 0 → command in cycle 1 → ready in cycle 2 → IDLE in cycle 3.
- Streak (updated only on a grant in IDLE):
  - DATA grant with if_req high: streak = min(streak+1, MAX_STREAK).
  - IF grant, or DATA grant with if_req low: streak = 0.
- rdata registers hold their value until the next read completes for that requester.
- Requests dropped while not owning the port are simply not granted. Requests dropped during BUSY do not abort the access; completion still pulses ready.
- No alignment checking; the full address is passed through unchanged.

Decomposition:
- Shared package dmem_arb_pkg:
  - state encoding localparams: IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2
  - owner encoding: OWN_IF = 1'b0, OWN_D = 1'b1
- No sub-module is needed; the latency counter and the streak counter are inline. The package is also used by the hazard unit.

Test Plan:
- Single store: d_req=1, d_we=1, d_addr=0x12, d_wdata=0x55 → m_write_en=1, m_address=0x12 for 1 cycle; d_ready pulses 2 cycles after the request; d_rdata stays 0.
- Load after store: d_req=1, d_we=0, d_addr=0x12 → m_read_en=1; d_rdata=0x55 with d_ready; if_ready stays 0.
- Simultaneous requests: if_req and d_req both high from cycle 0 with MAX_STREAK=4 and data held high → exactly 4 data grants, then 1 IF grant, then data again; if_rdata matches the memory word at if_addr.
- Fetch only: if_req=1, if_addr=0x40 with memory[0x40]=0xDEADBEEF → if_ready in cycle 2, if_rdata=0xDEADBEEF, m_write_en never asserted.
- MEM_LAT=3: load → m_read_en held for 3 cycles, d_ready in cycle 4, only one grant per 5 cycles.
- Reset mid-BUSY: assert reset during the command cycle of a store → m_write_en drops immediately, no d_ready; after release, the state is IDLE and a new load completes normally.
